pen_locator: RTL and testbench

Light-pen receiver for the 8x8 LED matrix: samples the pen photodiode against the live scan position and resolves which pixel the pen is over. It sits beside the LED driver, taking the same one-hot row/column scan vectors, and produces confirmed pen coordinates plus a one-cycle write strobe for the display RAM path. Debouncing is frame-based: a position must repeat over consecutive frames before it is reported, and the pen is declared lost after a run of empty frames.

---
 rtl/pen_locator.sv | 165 ++++++++++++++++
 tb/tb_pen_locator.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pen_locator.sv
// Light-pen receiver for the 8x8 LED matrix. Aligns the synchronised pen level
// with the delayed scan address, then debounces pen positions over whole frames.
module pen_locator #(
  parameter int LAT     = 2,
  parameter int CONFIRM = 2,
  parameter int LOST    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       pen_raw,
  input  logic [7:0] led_row,
  input  logic [7:0] led_col,
  output logic       hit_valid,
  output logic [2:0] hit_row,
  output logic [2:0] hit_col,
  output logic       pen_present,
  output logic [0:0] dbg_state
);

  // Two synchroniser stages plus LAT pen-path clocks.
  localparam int DLY = LAT + 2;

  localparam logic [0:0] SEEK = 1'b0;
  localparam logic [0:0] LOCK = 1'b1;

  localparam logic [2:0] CONFIRM_C = 3'(CONFIRM);
  localparam logic [3:0] LOST_C    = 4'(LOST);

  function automatic logic [2:0] enc8(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  function automatic logic onehot8(input logic [7:0] v);
    return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
  endfunction

  logic             r_pen_s1;
  logic             r_pen_s2;
  logic [DLY*6-1:0] r_dly_addr;
  logic [DLY-1:0]   r_dly_vld;
  logic [5:0]       r_prev_addr;
  logic [0:0]       r_state;
  logic [2:0]       r_cnt;
  logic [3:0]       r_miss;
  logic [5:0]       r_cand;
  logic             r_frame_hit;
  logic [5:0]       r_frame_addr;
  logic             r_hit_valid;
  logic [5:0]       r_hit_addr;
  logic             r_pen_present;

  logic [5:0] w_scan_addr;
  logic       w_scan_vld;
  logic [5:0] w_a_addr;
  logic       w_a_vld;
  logic       w_frame_end;
  logic       w_pen_hit;
  logic [2:0] w_cnt_next;
  logic [3:0] w_miss_next;

  assign w_scan_addr = {enc8(led_row), enc8(led_col)};
  assign w_scan_vld  = onehot8(led_row) && onehot8(led_col);

  assign w_a_addr = r_dly_addr[DLY*6-1 -: 6];
  assign w_a_vld  = r_dly_vld[DLY-1];

  // Non-one-hot cycles neither hit nor advance the frame.
  assign w_frame_end = w_a_vld && (w_a_addr == 6'd0) && (r_prev_addr != 6'd0);
  assign w_pen_hit   = w_a_vld && r_pen_s2;

  assign w_cnt_next  = (r_frame_addr == r_cand) ?
                       ((r_cnt == 3'd7) ? 3'd7 : r_cnt + 3'd1) : 3'd1;
  assign w_miss_next = r_miss + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pen_s1    <= 1'b0;
      r_pen_s2    <= 1'b0;
      r_dly_addr  <= '0;
      r_dly_vld   <= '0;
      r_prev_addr <= 6'd0;
    end else begin
      r_pen_s1   <= pen_raw;
      r_pen_s2   <= r_pen_s1;
      r_dly_addr <= {r_dly_addr[(DLY-1)*6-1:0], w_scan_addr};
      r_dly_vld  <= {r_dly_vld[DLY-2:0], w_scan_vld};
      if (w_a_vld) r_prev_addr <= w_a_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= SEEK;
      r_cnt         <= 3'd0;
      r_miss        <= 4'd0;
      r_cand        <= 6'd0;
      r_frame_hit   <= 1'b0;
      r_frame_addr  <= 6'd0;
      r_hit_valid   <= 1'b0;
      r_hit_addr    <= 6'd0;
      r_pen_present <= 1'b0;
    end else if (!en) begin
      r_state       <= SEEK;
      r_cnt         <= 3'd0;
      r_miss        <= 4'd0;
      r_frame_hit   <= 1'b0;
      r_hit_valid   <= 1'b0;
      r_pen_present <= 1'b0;
    end else begin
      r_hit_valid <= 1'b0;
      if (w_frame_end) begin
        // A hit in the frame-end cycle is the first pixel of the new frame.
        r_frame_hit <= w_pen_hit;
        if (w_pen_hit) r_frame_addr <= w_a_addr;
        case (r_state)
          SEEK: begin
            if (r_frame_hit) begin
              r_cand <= r_frame_addr;
              r_cnt  <= w_cnt_next;
              if (w_cnt_next >= CONFIRM_C) begin
                r_state       <= LOCK;
                r_hit_valid   <= 1'b1;
                r_hit_addr    <= r_frame_addr;
                r_pen_present <= 1'b1;
                r_miss        <= 4'd0;
              end
            end else begin
              r_cnt <= 3'd0;
            end
          end
          default: begin
            if (r_frame_hit) begin
              r_hit_valid <= 1'b1;
              r_hit_addr  <= r_frame_addr;
              r_miss      <= 4'd0;
            end else if (w_miss_next >= LOST_C) begin
              r_state       <= SEEK;
              r_pen_present <= 1'b0;
              r_cnt         <= 3'd0;
              r_miss        <= 4'd0;
            end else begin
              r_miss <= w_miss_next;
            end
          end
        endcase
      end else if (w_pen_hit && !r_frame_hit) begin
        r_frame_hit  <= 1'b1;
        r_frame_addr <= w_a_addr;
      end
    end
  end

  assign hit_valid   = r_hit_valid;
  assign hit_row     = r_hit_addr[5:3];
  assign hit_col     = r_hit_addr[2:0];
  assign pen_present = r_pen_present;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_pen_locator.sv
// Directed bench for pen_locator: three instances (LAT 0, 2, 5) share one scan
// stream; each sees the pen delayed by its own amount.
module tb_pen_locator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic [7:0] led_row = 8'd0;
  logic [7:0] led_col = 8'd0;
  logic [2:0] pr = 3'b000;
  logic [2:0] hv;
  logic [2:0] hr [3];
  logic [2:0] hc [3];
  logic [2:0] pp;
  logic [0:0] ds [3];

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] hist = 16'd0;
  int d [3] = '{0, 2, 5};
  int cyc = 0;
  int pcnt [3];
  int pcyc [3];
  int fall_cyc [3];
  logic pp_prev [3];

  always #5 clk = ~clk;

  pen_locator #(.LAT(0)) u_lat0 (
    .clk(clk), .rst_n(rst_n), .en(en), .pen_raw(pr[0]), .led_row(led_row), .led_col(led_col),
    .hit_valid(hv[0]), .hit_row(hr[0]), .hit_col(hc[0]), .pen_present(pp[0]), .dbg_state(ds[0]));
  pen_locator #(.LAT(2)) u_lat2 (
    .clk(clk), .rst_n(rst_n), .en(en), .pen_raw(pr[1]), .led_row(led_row), .led_col(led_col),
    .hit_valid(hv[1]), .hit_row(hr[1]), .hit_col(hc[1]), .pen_present(pp[1]), .dbg_state(ds[1]));
  pen_locator #(.LAT(5)) u_lat5 (
    .clk(clk), .rst_n(rst_n), .en(en), .pen_raw(pr[2]), .led_row(led_row), .led_col(led_col),
    .hit_valid(hv[2]), .hit_row(hr[2]), .hit_col(hc[2]), .pen_present(pp[2]), .dbg_state(ds[2]));

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    cyc = 0;
    for (int k = 0; k < 3; k++) begin
      pcnt[k] = 0;
      pcyc[k] = -1;
      fall_cyc[k] = -1;
      pp_prev[k] = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b1;
    led_row = 8'd0;
    led_col = 8'd0;
    hist = 16'd0;
    pr = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_stats();
  endtask

  // Drive one scan cycle; pen_raw of instance k follows the wanted level by d[k] clocks.
  task automatic tick(input logic [7:0] row, input logic [7:0] col, input logic want);
    hist = {hist[14:0], want};
    led_row = row;
    led_col = col;
    for (int k = 0; k < 3; k++) pr[k] = hist[d[k]];
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      if (hv[k]) begin
        pcnt[k]++;
        pcyc[k] = cyc;
      end
      if (pp_prev[k] && !pp[k] && fall_cyc[k] < 0) fall_cyc[k] = cyc;
      pp_prev[k] = pp[k];
    end
    cyc++;
  endtask

  task automatic run_frame(input int tr, input int tc, input logic lit);
    logic [7:0] rv;
    logic [7:0] cv;
    for (int i = 0; i < 64; i++) begin
      rv = 8'd1 << (i / 8);
      cv = 8'd1 << (i % 8);
      tick(rv, cv, lit && ((i / 8) == tr) && ((i % 8) == tc));
    end
  endtask

  initial begin
    clear_stats();

    // Reset state
    do_reset();
    check("rst_hit_valid", hv[1], 0);
    check("rst_hit_row", hr[1], 0);
    check("rst_hit_col", hc[1], 0);
    check("rst_pen_present", pp[1], 0);
    check("rst_state", ds[1], 0);

    // Lock at (3,5), all three latencies
    run_frame(3, 5, 1'b1);
    run_frame(3, 5, 1'b1);
    check("lock_no_early_pulse", pcnt[1], 0);
    run_frame(0, 0, 1'b0);
    check("lock_count", pcnt[1], 1);
    check("lock_cycle", pcyc[1], 132);
    check("lock_row", hr[1], 3);
    check("lock_col", hc[1], 5);
    check("lock_present", pp[1], 1);
    check("lock_state", ds[1], 1);
    check("lat0_count", pcnt[0], 1);
    check("lat0_cycle", pcyc[0], 130);
    check("lat0_row", hr[0], 3);
    check("lat0_col", hc[0], 5);
    check("lat5_count", pcnt[2], 1);
    check("lat5_cycle", pcyc[2], 135);
    check("lat5_row", hr[2], 3);
    check("lat5_col", hc[2], 5);

    // Move to (6,1) while locked
    run_frame(6, 1, 1'b1);
    run_frame(0, 0, 1'b0);
    check("move_count", pcnt[1], 2);
    check("move_cycle", pcyc[1], 260);
    check("move_row", hr[1], 6);
    check("move_col", hc[1], 1);
    check("move_present", pp[1], 1);
    check("move_no_drop", fall_cyc[1], -1);

    // Jitter: (2,2), (2,3), (2,3)
    do_reset();
    run_frame(2, 2, 1'b1);
    run_frame(2, 3, 1'b1);
    check("jit_after_f1", pcnt[1], 0);
    run_frame(2, 3, 1'b1);
    check("jit_after_f2", pcnt[1], 0);
    run_frame(0, 0, 1'b0);
    check("jit_count", pcnt[1], 1);
    check("jit_cycle", pcyc[1], 196);
    check("jit_row", hr[1], 2);
    check("jit_col", hc[1], 3);

    // Loss after 4 dark frames
    do_reset();
    run_frame(1, 1, 1'b1);
    run_frame(1, 1, 1'b1);
    for (int f = 0; f < 5; f++) run_frame(0, 0, 1'b0);
    check("loss_fall_cycle", fall_cyc[1], 388);
    check("loss_present", pp[1], 0);
    check("loss_state", ds[1], 0);
    check("loss_count", pcnt[1], 1);

    // 3 dark frames then a hit keeps lock
    do_reset();
    run_frame(1, 1, 1'b1);
    run_frame(1, 1, 1'b1);
    for (int f = 0; f < 3; f++) run_frame(0, 0, 1'b0);
    run_frame(4, 7, 1'b1);
    run_frame(0, 0, 1'b0);
    check("keep_count", pcnt[1], 2);
    check("keep_cycle", pcyc[1], 388);
    check("keep_row", hr[1], 4);
    check("keep_col", hc[1], 7);
    check("keep_present", pp[1], 1);
    check("keep_no_drop", fall_cyc[1], -1);

    // Pen one clock later than LAT=5 expects: one column late
    do_reset();
    d[2] = 6;
    run_frame(3, 5, 1'b1);
    run_frame(3, 5, 1'b1);
    run_frame(0, 0, 1'b0);
    check("late_count", pcnt[2], 1);
    check("late_row", hr[2], 3);
    check("late_col", hc[2], 6);
    d[2] = 5;

    // Non-one-hot stretch with pen lit: no hits, no frame ends
    do_reset();
    run_frame(3, 5, 1'b1);
    for (int i = 0; i < 35; i++) tick(8'h01, 8'h00, 1'b1);
    for (int i = 0; i < 35; i++) tick(8'h08, 8'h03, 1'b1);
    check("dis_no_pulse", pcnt[1], 0);
    check("dis_no_lock", pp[1], 0);
    run_frame(3, 5, 1'b1);
    run_frame(0, 0, 1'b0);
    check("dis_count", pcnt[1], 1);
    check("dis_cycle", pcyc[1], 202);
    check("dis_row", hr[1], 3);
    check("dis_col", hc[1], 5);
    check("dis_lat0_cycle", pcyc[0], 200);

    // Asynchronous reset mid-frame
    do_reset();
    run_frame(3, 5, 1'b1);
    run_frame(3, 5, 1'b1);
    run_frame(0, 0, 1'b0);
    for (int i = 0; i < 10; i++) tick(8'h01, 8'd1 << i % 8, 1'b0);
    check("pre_rst_present", pp[1], 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_hit_valid", hv[1], 0);
    check("arst_hit_row", hr[1], 0);
    check("arst_hit_col", hc[1], 0);
    check("arst_present", pp[1], 0);

    // Drop en while locked, then reacquire at (5,2)
    do_reset();
    run_frame(3, 5, 1'b1);
    run_frame(3, 5, 1'b1);
    run_frame(0, 0, 1'b0);
    en = 1'b0;
    run_frame(3, 5, 1'b1);
    check("en_fall_cycle", fall_cyc[1], 192);
    check("en_present", pp[1], 0);
    check("en_row_held", hr[1], 3);
    check("en_col_held", hc[1], 5);
    check("en_no_pulse", pcnt[1], 1);
    en = 1'b1;
    run_frame(5, 2, 1'b1);
    run_frame(5, 2, 1'b1);
    run_frame(0, 0, 1'b0);
    check("reacq_count", pcnt[1], 2);
    check("reacq_cycle", pcyc[1], 388);
    check("reacq_row", hr[1], 5);
    check("reacq_col", hc[1], 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
